button_press_decoder: RTL
=========================

Name: button_press_decoder

Overview:
- Sits directly downstream of the one-bit debouncer; consumes its clean button level and turns it into single-cycle event pulses for the LED display control logic.
- Classifies each press as short or long, generates auto-repeat pulses while a long press is held, and keeps a wrapping press counter.
- Clocked on the same system clock as the debouncer.

Parameters:
- LONG_CYCLES, 50000000, consecutive high samples needed to classify a press as long; legal range is 2 or more.
- REPEAT_CYCLES, 10000000, period in samples of auto-repeat pulses after a long press; 0 disables auto-repeat.
- CNT_WIDTH, 27, width of the hold and repeat counters; must hold LONG_CYCLES and REPEAT_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_level  input  1  debounced button level from the debouncer; 1 = pressed.
- press_pulse  output  1  one-cycle pulse on the accepted press edge.
- short_pulse  output  1  one-cycle pulse on release of a press shorter than LONG_CYCLES.
- long_pulse  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while the long hold continues.
- release_pulse  output  1  one-cycle pulse on any release following an accepted press.
- held  output  1  high while in PRESSED or LONG_HOLD.
- press_count  output  8  count of accepted presses, wraps 255 to 0.

Behaviour:
- Interface decision: one clock domain on clk; rst is synchronous and active-high.
- Reset:
  - Applies on a clk edge with rst=1 and has priority over everything else, including mid-press.
  - State goes to WAIT_RELEASE and both counters clear.
  - All pulse outputs, held and press_count go to 0.
- All outputs are registered. Each pulse is high for exactly the one cycle that follows the clk edge on which its condition is sampled.
- WAIT_RELEASE:
  - Ignores a high btn_level.
  - Moves to IDLE on the first edge where btn_level=0.
  - A button held through reset therefore never produces a press.
- IDLE:
  - On btn_level=1: go to PRESSED, hold_cnt<=1, press_pulse<=1, press_count<=press_count+1, held<=1.
- PRESSED:
  - btn_level=0: short_pulse<=1, release_pulse<=1, held<=0, go to IDLE.
  - btn_level=1 and hold_cnt==LONG_CYCLES-1: long_pulse<=1, rep_cnt<=0, go to LONG_HOLD.
  - Otherwise hold_cnt increments.
  - long_pulse therefore occurs on the LONG_CYCLES-th consecutive high sample, counting the press edge as sample 1.
- LONG_HOLD:
  - btn_level=0: release_pulse<=1, held<=0, go to IDLE. short_pulse is never issued.
  - btn_level=1 with REPEAT_CYCLES>0: rep_cnt increments. When rep_cnt==REPEAT_CYCLES-1, repeat_pulse<=1 and rep_cnt<=0.
  - The first repeat comes REPEAT_CYCLES samples after long_pulse; repeats continue indefinitely.
  - btn_level=1 with REPEAT_CYCLES==0: hold with no pulses.
- Simultaneous events:
  - A release on the same sample that would complete LONG_CYCLES or a repeat period counts as a release: no long_pulse or repeat_pulse.
  - A re-press on the sample right after release is accepted, since IDLE is entered immediately.
  - Minimum event spacing is 1 cycle.
- Counters never exceed their terminal values, so there is no counter overflow. press_count wraps modulo 256.
- At most one of press, short, long and repeat pulses is high in any cycle. release_pulse may coincide only with short_pulse.
- Unused state encodings return to WAIT_RELEASE.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4):
- Reset with btn_level=0, then btn_level high for 3 cycles then low -> press_pulse 1 cycle after the first high edge; short_pulse and release_pulse together 1 cycle after the first low edge; press_count=1; long_pulse never.
- btn_level held high for 20 cycles -> long_pulse after high sample 8; repeat_pulse after samples 12, 16 and 20; on release, release_pulse only, with no short_pulse.
- btn_level high, rst pulsed at sample 5, rst released with button still high for 10 cycles, then low, then high -> no pulses until the re-press; press_pulse on the re-press; press_count=1 after that press.
- Release exactly on sample 8 (7 high samples, then low) -> short_pulse asserted, no long_pulse. Release on sample 12 of a long hold -> no repeat_pulse.
- 257 short presses, each 2 high cycles and 1 low cycle -> press_count reads 1 after wrapping; no missed or doubled press_pulse.
- REPEAT_CYCLES=0 with a 30-cycle hold -> a single long_pulse, zero repeat_pulse, and held=1 throughout.

Source files
------------

// File: rtl/button_press_decoder.sv
// Button press decoder: turns a debounced button level into single-cycle
// press / short / long / repeat / release events plus a wrapping press count.
// All outputs are registered; the combinational process computes the value
// each register takes on the next clk edge.
module button_press_decoder #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_WIDTH     = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       release_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  // Three-bit encoding leaves spare codes; any of them falls back to WAIT_RELEASE.
  typedef enum logic [2:0] {
    WAIT_RELEASE = 3'd0,
    IDLE         = 3'd1,
    PRESSED      = 3'd2,
    LONG_HOLD    = 3'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam bit                   REP_EN    = (REPEAT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] REP_LAST  =
    CNT_WIDTH'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] hold_cnt, hold_nx;
  logic [CNT_WIDTH-1:0] rep_cnt, rep_nx;
  logic                 press_nx, short_nx, long_nx, repeat_nx, release_nx, held_nx;
  logic [7:0]           count_nx;

  // Next-state, counter and output decode; a release always wins over a
  // terminal count reached on the same sample.
  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    rep_nx     = rep_cnt;
    press_nx   = 1'b0;
    short_nx   = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    release_nx = 1'b0;
    count_nx   = press_count;
    case (state)
      WAIT_RELEASE: begin
        if (!btn_level) state_nx = IDLE;
      end
      IDLE: begin
        if (btn_level) begin
          state_nx = PRESSED;
          hold_nx  = CNT_ONE;
          press_nx = 1'b1;
          count_nx = press_count + 8'd1;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_nx   = IDLE;
          short_nx   = 1'b1;
          release_nx = 1'b1;
        end else if (hold_cnt == LONG_LAST) begin
          state_nx = LONG_HOLD;
          long_nx  = 1'b1;
          rep_nx   = '0;
        end else begin
          hold_nx = hold_cnt + CNT_ONE;
        end
      end
      LONG_HOLD: begin
        if (!btn_level) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
        end else if (REP_EN) begin
          if (rep_cnt == REP_LAST) begin
            repeat_nx = 1'b1;
            rep_nx    = '0;
          end else begin
            rep_nx = rep_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nx = WAIT_RELEASE;
      end
    endcase
    held_nx = (state_nx == PRESSED) || (state_nx == LONG_HOLD);
  end

  // State, counters and registered outputs; reset forces a fresh release wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_RELEASE;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_nx;
      hold_cnt      <= hold_nx;
      rep_cnt       <= rep_nx;
      press_pulse   <= press_nx;
      short_pulse   <= short_nx;
      long_pulse    <= long_nx;
      repeat_pulse  <= repeat_nx;
      release_pulse <= release_nx;
      held          <= held_nx;
      press_count   <= count_nx;
    end
  end

endmodule
